// File: rtl/snoop_bus_arbiter.sv
// Two-CPU snooping coherence bus arbiter: round-robin owner select, tag snoop of the other cache,
// then grant / data-source select / remote invalidate. Optional WAIT watchdog enabled by `BUS_WDOG_EN.
module snoop_bus_arbiter #(
  parameter int unsigned SNOOP_CYCLES = 1,
  parameter int unsigned TIMEOUT      = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read_miss0,
  input  logic        read_miss1,
  input  logic        write_miss0,
  input  logic        write_miss1,
  input  logic        invalidate0,
  input  logic        invalidate1,
  input  logic [10:0] BICO0,
  input  logic [10:0] BICO1,
  input  logic        cpu_search_found0,
  input  logic        cpu_search_found1,
  input  logic [1:0]  block_state0,
  input  logic [1:0]  block_state1,
  output logic        grant0,
  output logic        grant1,
  output logic        cpu_search0,
  output logic        cpu_search1,
  output logic [10:0] BOCI0,
  output logic [10:0] BOCI1,
  output logic        cpu_datasel0,
  output logic        cpu_datasel1,
  output logic        invalidate_from_other_cpu0,
  output logic        invalidate_from_other_cpu1,
  output logic        snoop_dirty,
  output logic        bus_err,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SNOOP = 2'd1,
    ST_RESP  = 2'd2,
    ST_WAIT  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    TY_READ  = 2'd0,
    TY_WRITE = 2'd1,
    TY_INV   = 2'd2
  } txn_e;

  localparam logic [3:0] SNOOP_LAST = 4'(SNOOP_CYCLES - 1);

  // Handshake: a CPU raises read_miss/write_miss/invalidate (level) and must hold it until its
  // one-cycle grant; the transaction is owned until the owner drops the request in WAIT.
  logic [1:0]  req;
  logic        req_owner;
  logic        found_other;
  logic [1:0]  state_other;

  state_e      state_q, state_d;
  txn_e        type_q, type_d;
  logic        owner_q, owner_d;
  logic        rr_q, rr_d;
  logic [10:0] tag_q, tag_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        found_q, found_d;
  logic        dirty_q, dirty_d;

  logic [1:0]  grant_q, grant_d;
  logic [1:0]  search_q, search_d;
  logic [1:0]  dsel_q, dsel_d;
  logic [1:0]  inv_q, inv_d;
  logic [10:0] boci0_q, boci0_d;
  logic [10:0] boci1_q, boci1_d;
  logic        snoop_dirty_q, snoop_dirty_d;

`ifdef BUS_WDOG_EN
  localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT - 1);
  logic [15:0] wdog_q, wdog_d;
  logic        bus_err_q, bus_err_d;
`else
  logic [15:0] timeout_unused;
  assign timeout_unused = 16'(TIMEOUT);
`endif

  function automatic txn_e pick_type(input logic wm, input logic rm);
    if (wm) return TY_WRITE;
    if (rm) return TY_READ;
    return TY_INV;
  endfunction

  assign req = {read_miss1 | write_miss1 | invalidate1, read_miss0 | write_miss0 | invalidate0};
  assign req_owner   = owner_q ? req[1] : req[0];
  // The snooped cache is always the one that does not own the bus.
  assign found_other = owner_q ? cpu_search_found0 : cpu_search_found1;
  assign state_other = owner_q ? block_state0 : block_state1;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    type_d  = type_q;
    tag_d   = tag_q;
    cnt_d   = cnt_q;
    found_d = found_q;
    dirty_d = dirty_q;
    rr_d    = rr_q;
`ifdef BUS_WDOG_EN
    wdog_d    = wdog_q;
    bus_err_d = bus_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          owner_d = (&req) ? rr_q : req[1];
          if (owner_d) begin
            type_d = pick_type(write_miss1, read_miss1);
            tag_d  = BICO1;
          end else begin
            type_d = pick_type(write_miss0, read_miss0);
            tag_d  = BICO0;
          end
          cnt_d   = SNOOP_LAST;
          found_d = 1'b0;
          dirty_d = 1'b0;
          state_d = ST_SNOOP;
        end
      end
      ST_SNOOP: begin
        if (cnt_q == 4'd0) begin
          found_d = found_other;
          dirty_d = found_other & (state_other == 2'b10);
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        rr_d    = ~owner_q;
        state_d = ST_WAIT;
`ifdef BUS_WDOG_EN
        wdog_d  = 16'd0;
`endif
      end
      ST_WAIT: begin
        if (!req_owner) begin
          state_d = ST_IDLE;
        end
`ifdef BUS_WDOG_EN
        else if (wdog_q == WDOG_LAST) begin
          bus_err_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          wdog_d = wdog_q + 16'd1;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next-state view so they line up with the state they describe.
  always_comb begin
    grant_d       = 2'b00;
    search_d      = 2'b00;
    dsel_d        = 2'b00;
    inv_d         = 2'b00;
    snoop_dirty_d = 1'b0;
    boci0_d       = 11'd0;
    boci1_d       = 11'd0;
    if (state_d != ST_IDLE) begin
      boci0_d = tag_d;
      boci1_d = tag_d;
    end
    case (state_d)
      ST_SNOOP: search_d[~owner_d] = 1'b1;
      ST_RESP: begin
        grant_d[owner_d] = 1'b1;
        dsel_d[owner_d]  = found_d & (type_d != TY_INV);
        inv_d[~owner_d]  = found_d & (type_d != TY_READ);
        snoop_dirty_d    = dirty_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      type_q        <= TY_READ;
      owner_q       <= 1'b0;
      rr_q          <= 1'b0;
      tag_q         <= 11'd0;
      cnt_q         <= 4'd0;
      found_q       <= 1'b0;
      dirty_q       <= 1'b0;
      grant_q       <= 2'b00;
      search_q      <= 2'b00;
      dsel_q        <= 2'b00;
      inv_q         <= 2'b00;
      boci0_q       <= 11'd0;
      boci1_q       <= 11'd0;
      snoop_dirty_q <= 1'b0;
`ifdef BUS_WDOG_EN
      wdog_q        <= 16'd0;
      bus_err_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      type_q        <= type_d;
      owner_q       <= owner_d;
      rr_q          <= rr_d;
      tag_q         <= tag_d;
      cnt_q         <= cnt_d;
      found_q       <= found_d;
      dirty_q       <= dirty_d;
      grant_q       <= grant_d;
      search_q      <= search_d;
      dsel_q        <= dsel_d;
      inv_q         <= inv_d;
      boci0_q       <= boci0_d;
      boci1_q       <= boci1_d;
      snoop_dirty_q <= snoop_dirty_d;
`ifdef BUS_WDOG_EN
      wdog_q        <= wdog_d;
      bus_err_q     <= bus_err_d;
`endif
    end
  end

  assign grant0                     = grant_q[0];
  assign grant1                     = grant_q[1];
  assign cpu_search0                = search_q[0];
  assign cpu_search1                = search_q[1];
  assign BOCI0                      = boci0_q;
  assign BOCI1                      = boci1_q;
  assign cpu_datasel0               = dsel_q[0];
  assign cpu_datasel1               = dsel_q[1];
  assign invalidate_from_other_cpu0 = inv_q[0];
  assign invalidate_from_other_cpu1 = inv_q[1];
  assign snoop_dirty                = snoop_dirty_q;
  assign state_dbg                  = state_q;
`ifdef BUS_WDOG_EN
  assign bus_err                    = bus_err_q;
`else
  assign bus_err                    = 1'b0;
`endif

  a_grant_onehot: assert property (@(posedge clk) disable iff (rst) !(grant_q[0] && grant_q[1]));
  a_grant_in_resp: assert property (@(posedge clk) disable iff (rst)
    ((grant_q != 2'b00) == (state_q == ST_RESP)));

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Bench for snoop_bus_arbiter: directed scenarios plus randomized transactions checked
// against a transaction-level model of owner selection, timing and response fields.
module tb_snoop_bus_arbiter;
  localparam int S  = 3;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst;
  logic [1:0]       rm, wm, iv, fnd;
  logic [1:0][10:0] bico;
  logic [1:0][1:0]  bst;
  logic [1:0]       gnt, srch, dsel, inv;
  logic [1:0][10:0] boci;
  logic             snoop_dirty, bus_err;
  logic [1:0]       state_dbg;

  int   n_cmp = 0;
  int   n_err = 0;
  int   prefer;
  logic exp_err;

  always #5 clk = ~clk;

  snoop_bus_arbiter #(.SNOOP_CYCLES(S), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .read_miss0(rm[0]), .read_miss1(rm[1]),
    .write_miss0(wm[0]), .write_miss1(wm[1]),
    .invalidate0(iv[0]), .invalidate1(iv[1]),
    .BICO0(bico[0]), .BICO1(bico[1]),
    .cpu_search_found0(fnd[0]), .cpu_search_found1(fnd[1]),
    .block_state0(bst[0]), .block_state1(bst[1]),
    .grant0(gnt[0]), .grant1(gnt[1]),
    .cpu_search0(srch[0]), .cpu_search1(srch[1]),
    .BOCI0(boci[0]), .BOCI1(boci[1]),
    .cpu_datasel0(dsel[0]), .cpu_datasel1(dsel[1]),
    .invalidate_from_other_cpu0(inv[0]), .invalidate_from_other_cpu1(inv[1]),
    .snoop_dirty(snoop_dirty), .bus_err(bus_err), .state_dbg(state_dbg)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drop(input int c);
    rm[c] = 1'b0;
    wm[c] = 1'b0;
    iv[c] = 1'b0;
  endtask

  task automatic new_req(input int c);
    logic [2:0] r;
    r = 3'($urandom_range(1, 7));
    wm[c]   = r[2];
    rm[c]   = r[1];
    iv[c]   = r[0];
    bico[c] = 11'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1; rm = '0; wm = '0; iv = '0; fnd = '0; bico = '0; bst = '0;
    step(); step();
    n_cmp++;
    if ({gnt, srch, dsel, inv, snoop_dirty, bus_err} !== 10'b0) begin
      n_err++; $display("FAIL reset_ctrl got=%b exp=0", {gnt, srch, dsel, inv, snoop_dirty, bus_err});
    end
    n_cmp++;
    if (boci !== '0) begin n_err++; $display("FAIL reset_boci got=%h exp=0", boci); end
    n_cmp++;
    if (state_dbg !== 2'd0) begin n_err++; $display("FAIL reset_state got=%0d exp=0", state_dbg); end
    rst = 1'b0; prefer = 0; exp_err = 1'b0;
    step();
    n_cmp++;
    if (gnt !== 2'b00 || srch !== 2'b00) begin
      n_err++; $display("FAIL reset_release gnt=%b srch=%b exp 00/00", gnt, srch);
    end
  endtask

  task automatic test_read_miss_clean();
    rm[0] = 1'b1; bico[0] = 11'h155; fnd[1] = 1'b0; bst[1] = 2'b00;
    for (int i = 0; i < S; i++) begin
      step();
      n_cmp++;
      if (srch !== 2'b10 || boci[1] !== 11'h155 || gnt !== 2'b00) begin
        n_err++; $display("FAIL rm_snoop cyc=%0d srch=%b boci1=%h gnt=%b exp 10/155/00", i, srch, boci[1], gnt);
      end
    end
    step();
    n_cmp++;
    if (gnt !== 2'b01 || dsel !== 2'b00 || inv !== 2'b00 || snoop_dirty !== 1'b0) begin
      n_err++; $display("FAIL rm_grant gnt=%b dsel=%b inv=%b dirty=%b exp 01/00/00/0", gnt, dsel, inv, snoop_dirty);
    end
    rm[0] = 1'b0; prefer = 1;
    step(); step();
    n_cmp++;
    if (state_dbg !== 2'd0 || boci !== '0 || gnt !== 2'b00) begin
      n_err++; $display("FAIL rm_idle state=%0d boci=%h gnt=%b exp 0/0/00", state_dbg, boci, gnt);
    end
  endtask

  task automatic test_write_miss_dirty();
    wm[1] = 1'b1; bico[1] = 11'h3A0; fnd[0] = 1'b1; bst[0] = 2'b10;
    for (int i = 0; i < S; i++) begin
      step();
      n_cmp++;
      if (srch !== 2'b01 || boci[0] !== 11'h3A0 || boci[1] !== 11'h3A0) begin
        n_err++; $display("FAIL wm_snoop cyc=%0d srch=%b boci=%h exp 01/3a0", i, srch, boci);
      end
    end
    step();
    n_cmp++;
    if (gnt !== 2'b10 || dsel !== 2'b10 || inv !== 2'b01 || snoop_dirty !== 1'b1) begin
      n_err++; $display("FAIL wm_grant gnt=%b dsel=%b inv=%b dirty=%b exp 10/10/01/1", gnt, dsel, inv, snoop_dirty);
    end
    wm[1] = 1'b0; fnd[0] = 1'b0; bst[0] = 2'b00; prefer = 0;
    step();
    n_cmp++;
    if (inv !== 2'b00 || gnt !== 2'b00) begin
      n_err++; $display("FAIL wm_pulse inv=%b gnt=%b exp 00/00", inv, gnt);
    end
    step();
  endtask

  task automatic test_priority_mix();
    wm[0] = 1'b1; iv[0] = 1'b1; bico[0] = 11'h2AB; fnd[1] = 1'b1; bst[1] = 2'b01;
    for (int i = 0; i < S; i++) step();
    step();
    n_cmp++;
    if (gnt !== 2'b01 || dsel !== 2'b01 || inv !== 2'b10 || snoop_dirty !== 1'b0) begin
      n_err++; $display("FAIL prio_grant gnt=%b dsel=%b inv=%b dirty=%b exp 01/01/10/0", gnt, dsel, inv, snoop_dirty);
    end
    drop(0); fnd = '0; bst = '0; prefer = 1;
    step(); step();
  endtask

  task automatic test_back_to_back();
    rst = 1'b1; step(); rst = 1'b0; prefer = 0; exp_err = 1'b0;
    rm = 2'b11; bico[0] = 11'h011; bico[1] = 11'h722; fnd = '0;
    for (int i = 0; i < S; i++) step();
    step();
    n_cmp++;
    if (gnt !== 2'b01) begin n_err++; $display("FAIL tie_first gnt=%b exp 01", gnt); end
    rm[0] = 1'b0;
    for (int i = 1; i <= S + 3; i++) begin
      step();
      n_cmp++;
      if (gnt !== ((i == S + 3) ? 2'b10 : 2'b00)) begin
        n_err++; $display("FAIL tie_second cyc=%0d gnt=%b exp %b", i, gnt, (i == S + 3) ? 2'b10 : 2'b00);
      end
    end
    rm[1] = 1'b0;
    step(); step();
    rm = 2'b11;
    for (int i = 0; i < S; i++) step();
    step();
    n_cmp++;
    if (gnt !== 2'b01) begin n_err++; $display("FAIL tie_again gnt=%b exp 01", gnt); end
    rm = 2'b00; prefer = 1;
    step(); step();
  endtask

  task automatic test_drop_in_snoop();
    rm[1] = 1'b1; bico[1] = 11'h0F0; fnd[0] = 1'b1; bst[0] = 2'b11;
    step();
    rm[1] = 1'b0;
    for (int i = 1; i < S; i++) step();
    step();
    n_cmp++;
    if (gnt !== 2'b10 || dsel !== 2'b10 || inv !== 2'b00 || snoop_dirty !== 1'b0) begin
      n_err++; $display("FAIL drop_grant gnt=%b dsel=%b inv=%b dirty=%b exp 10/10/00/0", gnt, dsel, inv, snoop_dirty);
    end
    prefer = 0; fnd = '0; bst = '0;
    step(); step();
    n_cmp++;
    if (state_dbg !== 2'd0) begin n_err++; $display("FAIL drop_idle state=%0d exp 0", state_dbg); end
  endtask

  task automatic test_reset_mid();
    iv[0] = 1'b1; bico[0] = 11'h444;
    for (int i = 0; i < S; i++) step();
    step();
    n_cmp++;
    if (gnt !== 2'b01 || inv !== 2'b00) begin n_err++; $display("FAIL rstmid_pre gnt=%b inv=%b exp 01/00", gnt, inv); end
    iv[0] = 1'b0; prefer = 1;
    step(); step();
    rm = 2'b11;
    step();
    n_cmp++;
    if (srch !== 2'b01) begin n_err++; $display("FAIL rstmid_snoop srch=%b exp 01", srch); end
    rst = 1'b1;
    step();
    n_cmp++;
    if ({gnt, srch, dsel, inv, snoop_dirty, bus_err} !== 10'b0 || boci !== '0 || state_dbg !== 2'd0) begin
      n_err++; $display("FAIL rstmid_clear ctrl=%b boci=%h state=%0d exp all 0",
                        {gnt, srch, dsel, inv, snoop_dirty, bus_err}, boci, state_dbg);
    end
    rst = 1'b0; prefer = 0; exp_err = 1'b0;
    for (int i = 1; i <= S; i++) begin
      step();
      n_cmp++;
      if (gnt !== 2'b00 || srch !== 2'b10) begin
        n_err++; $display("FAIL rstmid_restart cyc=%0d gnt=%b srch=%b exp 00/10", i, gnt, srch);
      end
    end
    step();
    n_cmp++;
    if (gnt !== 2'b01) begin n_err++; $display("FAIL rstmid_grant gnt=%b exp 01", gnt); end
    rm = 2'b00; prefer = 1;
    step(); step();
  endtask

  task automatic test_watchdog();
    rm[0] = 1'b1; bico[0] = 11'h5A5; fnd = '0;
    for (int i = 0; i < S; i++) step();
    step();
    n_cmp++;
    if (gnt !== 2'b01) begin n_err++; $display("FAIL wdog_grant gnt=%b exp 01", gnt); end
    prefer = 1;
`ifdef BUS_WDOG_EN
    for (int i = 1; i <= TO; i++) begin
      step();
      n_cmp++;
      if (bus_err !== 1'b0 || state_dbg !== 2'd3) begin
        n_err++; $display("FAIL wdog_hold cyc=%0d err=%b state=%0d exp 0/3", i, bus_err, state_dbg);
      end
    end
    step();
    n_cmp++;
    if (bus_err !== 1'b1 || state_dbg !== 2'd0) begin
      n_err++; $display("FAIL wdog_fire err=%b state=%0d exp 1/0", bus_err, state_dbg);
    end
    rm[0] = 1'b0; exp_err = 1'b1;
    step();
    n_cmp++;
    if (bus_err !== 1'b1 || state_dbg !== 2'd0) begin
      n_err++; $display("FAIL wdog_sticky err=%b state=%0d exp 1/0", bus_err, state_dbg);
    end
`else
    for (int i = 1; i <= TO + 4; i++) begin
      step();
      n_cmp++;
      if (bus_err !== 1'b0 || state_dbg !== 2'd3) begin
        n_err++; $display("FAIL wdog_off_hold cyc=%0d err=%b state=%0d exp 0/3", i, bus_err, state_dbg);
      end
    end
    rm[0] = 1'b0;
    step();
    n_cmp++;
    if (bus_err !== 1'b0 || state_dbg !== 2'd0) begin
      n_err++; $display("FAIL wdog_off_exit err=%b state=%0d exp 0/0", bus_err, state_dbg);
    end
`endif
  endtask

  task automatic test_random();
    int own, oth, ty, h, nw;
    logic f;
    logic [1:0] s, eg, ed, ei, es;
    logic [10:0] tag;
    f = 1'b0; s = 2'b00;
    for (int t = 0; t < 40; t++) begin
      for (int c = 0; c < 2; c++)
        if (!(rm[c] | wm[c] | iv[c]) && $urandom_range(0, 1) == 1) new_req(c);
      if ((rm | wm | iv) == 2'b00) new_req(int'($urandom_range(0, 1)));
      if ((rm | wm | iv) == 2'b11) own = prefer;
      else own = (rm[1] | wm[1] | iv[1]) ? 1 : 0;
      oth = 1 - own;
      ty  = wm[own] ? 1 : (rm[own] ? 0 : 2);
      tag = bico[own];
      es  = (oth == 1) ? 2'b10 : 2'b01;
      eg  = (own == 1) ? 2'b10 : 2'b01;
      for (int i = 1; i <= S; i++) begin
        step();
        n_cmp++;
        if (srch !== es || gnt !== 2'b00 || inv !== 2'b00 || boci[oth] !== tag) begin
          n_err++; $display("FAIL rand_snoop t=%0d cyc=%0d srch=%b gnt=%b inv=%b boci=%h exp srch=%b tag=%h",
                            t, i, srch, gnt, inv, boci[oth], es, tag);
        end
        fnd     = 2'($urandom_range(0, 3));
        bst[0]  = 2'($urandom_range(0, 3));
        bst[1]  = 2'($urandom_range(0, 3));
        bico[own] = 11'($urandom);
        f = fnd[oth];
        s = bst[oth];
      end
      step();
      ed = (f && ty != 2) ? eg : 2'b00;
      ei = (f && ty != 0) ? es : 2'b00;
      n_cmp++;
      if (gnt !== eg || dsel !== ed || inv !== ei || snoop_dirty !== (f && s == 2'b10) || srch !== 2'b00) begin
        n_err++; $display("FAIL rand_grant t=%0d gnt=%b dsel=%b inv=%b dirty=%b exp %b/%b/%b/%b",
                          t, gnt, dsel, inv, snoop_dirty, eg, ed, ei, (f && s == 2'b10));
      end
      prefer = oth;
      h  = $urandom_range(0, 3);
      nw = (h == 0) ? 1 : h;
      if (h == 0) drop(own);
      for (int i = 1; i <= nw; i++) begin
        step();
        n_cmp++;
        if (gnt !== 2'b00 || srch !== 2'b00 || inv !== 2'b00 || boci[own] !== tag) begin
          n_err++; $display("FAIL rand_wait t=%0d cyc=%0d gnt=%b srch=%b inv=%b boci=%h exp 00/00/00/%h",
                            t, i, gnt, srch, inv, boci[own], tag);
        end
        if (i == h) drop(own);
      end
      step();
      n_cmp++;
      if (state_dbg !== 2'd0 || gnt !== 2'b00 || boci !== '0 || bus_err !== exp_err) begin
        n_err++; $display("FAIL rand_idle t=%0d state=%0d gnt=%b boci=%h err=%b exp 0/00/0/%b",
                          t, state_dbg, gnt, boci, bus_err, exp_err);
      end
    end
    rm = '0; wm = '0; iv = '0;
    step(); step();
  endtask

  initial begin
    #500000;
    $display("FAIL sim_timeout summary not reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_read_miss_clean();
    test_write_miss_dirty();
    test_priority_mix();
    test_back_to_back();
    test_drop_in_snoop();
    test_reset_mid();
    test_watchdog();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
